// File: rtl/spi_column_loader.sv
// Assembles SPI bytes (low byte first) into 16-bit column words and streams them
// to a column buffer, resyncing to column 0 if a frame stalls mid-way.
//
// state | meaning
// S_LO  | awaiting the low byte of the next column word
// S_HI  | low byte held, awaiting the high byte
module spi_column_loader #(
  parameter int NUM_COLS       = 640,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic        resync_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]    COL_MAX  = 10'(NUM_COLS - 1);

  typedef enum logic {S_LO, S_HI} state_t;

  state_t          state;
  logic [2:0]      sync;
  logic [1:0]      arm_cnt;
  logic            armed;
  logic            evt;
  logic            evt_q;
  logic [7:0]      byte_q;
  logic [7:0]      lo_byte;
  logic [9:0]      col_idx;
  logic [CW-1:0]   idle_cnt;
  logic            mid_frame;

  // Edges are masked until the history flop has caught up after reset, so a
  // byte_valid already high at release is absorbed rather than seen as a byte.
  assign armed     = (arm_cnt == 2'd3);
  assign evt       = sync[1] & ~sync[2] & armed;
  assign mid_frame = (state == S_HI) || (col_idx != 10'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 3'b000;
      arm_cnt <= 2'd0;
      evt_q   <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      sync  <= {sync[1:0], byte_valid};
      evt_q <= evt;
      if (!armed)
        arm_cnt <= arm_cnt + 2'd1;
      if (evt)
        byte_q <= byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LO;
      lo_byte    <= 8'h00;
      col_idx    <= 10'd0;
      idle_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= 10'd0;
      wr_data    <= 16'h0000;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
      if (evt_q) begin
        idle_cnt <= '0;
        if (state == S_LO) begin
          lo_byte <= byte_q;
          state   <= S_HI;
        end else begin
          wr_en      <= 1'b1;
          wr_addr    <= col_idx;
          wr_data    <= {byte_q, lo_byte};
          frame_done <= (col_idx == COL_MAX);
          col_idx    <= (col_idx == COL_MAX) ? 10'd0 : col_idx + 10'd1;
          state      <= S_LO;
        end
      end else if (!mid_frame) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_MAX) begin
        resync_err <= 1'b1;
        state      <= S_LO;
        col_idx    <= 10'd0;
        idle_cnt   <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_column_loader.sv
// Bench for spi_column_loader: random byte streams compared against a
// transaction-level model of word pairing, column wrap and stall timeouts.
module tb_spi_column_loader;

  localparam int NC = 640;
  localparam int T  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        resync_err;

  spi_column_loader #(.NUM_COLS(NC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .resync_err(resync_err)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; bit fd;} wr_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  rs_q[$];
  int  fd_bad = 0;

  int          m_col;
  bit          m_pend;
  logic [7:0]  m_lo;
  int          m_last;
  int          exp_resync;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (wr_en) begin
      w.addr = int'(wr_addr);
      w.data = int'(wr_data);
      w.fd   = frame_done;
      got_q.push_back(w);
    end
    if (resync_err) rs_q.push_back(cyc);
    if (frame_done && !wr_en) fd_bad++;
  end

  // Model: bytes pair up low-then-high; a frame left mid-way for more than T
  // cycles between byte arrivals is abandoned and restarts at column 0.
  function automatic void model_reset();
    m_col = 0; m_pend = 0; m_lo = 8'h00; m_last = 0; exp_resync = 0;
    exp_q.delete();
  endfunction

  function automatic void model_advance(int now);
    if ((m_pend || m_col != 0) && (now - m_last > T)) begin
      exp_resync++;
      m_pend = 0;
      m_col  = 0;
    end
  endfunction

  function automatic void model_byte(logic [7:0] b, int now);
    wr_t w;
    model_advance(now);
    m_last = now;
    if (!m_pend) begin
      m_lo = b;
      m_pend = 1;
    end else begin
      w.addr = m_col;
      w.data = int'({b, m_lo});
      w.fd   = (m_col == NC - 1);
      exp_q.push_back(w);
      m_col  = (m_col + 1) % NC;
      m_pend = 0;
    end
  endfunction

  task automatic drive_byte(input logic [7:0] b, input int hold, input int gap, input int at_cyc);
    int guard = 0;
    @(posedge clk); #1;
    while (cyc < at_cyc && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    model_byte(b, cyc);
    byte_data = b;
    byte_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_byte(b, $urandom_range(4, 6), $urandom_range(4, 6), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    got_q.delete();
    rs_q.delete();
    fd_bad = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, resync_err} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%0d data=%h fd=%b rs=%b required all 0",
               wr_en, wr_addr, wr_data, frame_done, resync_err);
    end
    do_reset();
  endtask

  task automatic test_basic_pair();
    int lat = 0;
    bit found = 0;
    do_reset();
    send_byte(8'h34);
    @(posedge clk); #1;
    model_byte(8'h12, cyc);
    byte_data = 8'h12;
    byte_valid = 1'b1;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(posedge clk); #1;
      if (wr_en) begin found = 1; lat = i; end
    end
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (6) @(posedge clk);
    checks++;
    if (!found || lat < 3 || lat > 4) begin
      errors++;
      $display("FAIL pair_latency got=%0d (found=%0b) required 3..4", lat, found);
    end
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL pair_count got=%0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].addr !== 0 || got_q[0].data !== 32'h1234) begin
        errors++;
        $display("FAIL pair_word got addr=%0d data=%h required addr=0 data=1234",
                 got_q[0].addr, got_q[0].data);
      end
    end
  endtask

  task automatic test_full_frame();
    int n;
    do_reset();
    for (int i = 0; i < 2 * NC + 2; i++) send_byte(8'($urandom));
    repeat (20) @(posedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL frame_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data ||
          got_q[i].fd !== exp_q[i].fd) begin
        errors++;
        $display("FAIL frame_write[%0d] got addr=%0d data=%h fd=%0b required addr=%0d data=%h fd=%0b",
                 i, got_q[i].addr, got_q[i].data, got_q[i].fd,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].fd);
      end
    end
    checks++;
    if (fd_bad !== 0) begin
      errors++;
      $display("FAIL frame_done_stray got=%0d required 0", fd_bad);
    end
    checks++;
    if (rs_q.size() !== exp_resync) begin
      errors++;
      $display("FAIL frame_resync got=%0d required %0d", rs_q.size(), exp_resync);
    end
  endtask

  task automatic test_timeout();
    int r;
    do_reset();
    send_byte(8'hAA);
    r = m_last;
    repeat (T + 30) @(posedge clk);
    model_advance(cyc);
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_nowrite got=%0d writes required 0", got_q.size());
    end
    checks++;
    if (rs_q.size() !== exp_resync) begin
      errors++;
      $display("FAIL timeout_pulses got=%0d required %0d", rs_q.size(), exp_resync);
    end
    if (rs_q.size() > 0) begin
      checks++;
      if (rs_q[0] < r + T + 3 || rs_q[0] > r + T + 4) begin
        errors++;
        $display("FAIL timeout_time got cycle=%0d required %0d..%0d", rs_q[0], r + T + 3, r + T + 4);
      end
    end
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (10) @(posedge clk);
    checks++;
    if (got_q.size() !== 1 || got_q[0].addr !== 0 || got_q[0].data !== 32'h0201) begin
      errors++;
      $display("FAIL timeout_recover got n=%0d addr=%0d data=%h required n=1 addr=0 data=0201",
               got_q.size(), (got_q.size() > 0) ? got_q[0].addr : -1,
               (got_q.size() > 0) ? got_q[0].data : -1);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    send_byte(8'h11);
    drive_byte(8'h22, 4, 4, m_last + T);
    repeat (10) @(posedge clk);
    checks++;
    if (got_q.size() !== 1 || rs_q.size() !== 0) begin
      errors++;
      $display("FAIL boundary_equal got writes=%0d resyncs=%0d required 1 and 0", got_q.size(), rs_q.size());
    end else begin
      checks++;
      if (got_q[0].addr !== 0 || got_q[0].data !== 32'h2211) begin
        errors++;
        $display("FAIL boundary_equal_word got addr=%0d data=%h required addr=0 data=2211",
                 got_q[0].addr, got_q[0].data);
      end
    end
    send_byte(8'h33);
    drive_byte(8'h44, 4, 4, m_last + T + 1);
    send_byte(8'h55);
    repeat (10) @(posedge clk);
    checks++;
    if (rs_q.size() !== 1) begin
      errors++;
      $display("FAIL boundary_late_resync got=%0d required 1", rs_q.size());
    end
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL boundary_late_count got=%0d required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[1].addr !== 0 || got_q[1].data !== 32'h5544) begin
        errors++;
        $display("FAIL boundary_late_word got addr=%0d data=%h required addr=0 data=5544",
                 got_q[1].addr, got_q[1].data);
      end
    end
  endtask

  task automatic test_held_valid();
    do_reset();
    drive_byte(8'h5A, 50, 5, 0);
    send_byte(8'hC3);
    repeat (10) @(posedge clk);
    checks++;
    if (got_q.size() !== 1 || got_q[0].data !== 32'hC35A) begin
      errors++;
      $display("FAIL held_valid got n=%0d data=%h required n=1 data=c35a",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : -1);
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(8'h81 + 8'(i));
    repeat (5) @(posedge clk);
    checks++;
    if (got_q.size() !== 3 || wr_addr !== 10'd2) begin
      errors++;
      $display("FAIL midreset_pre got n=%0d addr=%0d required n=3 addr=2", got_q.size(), wr_addr);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, resync_err} !== 29'd0) begin
      errors++;
      $display("FAIL midreset_async got en=%b addr=%0d data=%h fd=%b rs=%b required all 0",
               wr_en, wr_addr, wr_data, frame_done, resync_err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    got_q.delete();
    rs_q.delete();
    repeat (3) @(posedge clk);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (10) @(posedge clk);
    checks++;
    if (got_q.size() !== 1 || got_q[0].addr !== 0 || got_q[0].data !== 32'h0201) begin
      errors++;
      $display("FAIL midreset_restart got n=%0d addr=%0d data=%h required n=1 addr=0 data=0201",
               got_q.size(), (got_q.size() > 0) ? got_q[0].addr : -1,
               (got_q.size() > 0) ? got_q[0].data : -1);
    end
  endtask

  task automatic test_valid_at_reset();
    @(posedge clk); #1;
    byte_data = 8'h55;
    byte_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    got_q.delete();
    rs_q.delete();
    repeat (10) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (5) @(posedge clk);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (10) @(posedge clk);
    checks++;
    if (got_q.size() !== 1 || got_q[0].addr !== 0 || got_q[0].data !== 32'h0201) begin
      errors++;
      $display("FAIL valid_at_reset got n=%0d addr=%0d data=%h required n=1 addr=0 data=0201",
               got_q.size(), (got_q.size() > 0) ? got_q[0].addr : -1,
               (got_q.size() > 0) ? got_q[0].data : -1);
    end
  endtask

  task automatic test_random();
    int n;
    int g;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: g = T - 1;
        1: g = T;
        2: g = T + 1;
        3: g = T + 7;
        default: g = $urandom_range(12, 40);
      endcase
      drive_byte(8'($urandom), 4, 4, m_last + g);
    end
    repeat (T + 30) @(posedge clk);
    model_advance(cyc);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL random_write[%0d] got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (rs_q.size() !== exp_resync) begin
      errors++;
      $display("FAIL random_resync got=%0d required %0d", rs_q.size(), exp_resync);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_pair();
    test_held_valid();
    test_timeout();
    test_timeout_boundary();
    test_mid_frame_reset();
    test_valid_at_reset();
    test_random();
    test_full_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_column_loader.md
SPI_COLUMN_LOADER -- requirements
Module: spi_column_loader

Interface
REQ-001 SHALL have parameter NUM_COLS, default 640, number of 16-bit column words per frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle clk cycles mid-frame before resync.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port byte_data  input  8  byte from SPI receive stage (SCK domain, stable while byte_valid high).
REQ-006 SHALL have port byte_valid  input  1  SPI stage "byte received" level (SCK domain; rises once per CS-low transaction, cleared when CS rises).
REQ-007 SHALL have port wr_en  output  1  one-cycle column-buffer write strobe.
REQ-008 SHALL have port wr_addr  output  10  column index 0..NUM_COLS-1 for the write.
REQ-009 SHALL have port wr_data  output  16  column word {high byte, low byte}.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse coincident with the write of column NUM_COLS-1.
REQ-011 SHALL have port resync_err  output  1  one-cycle pulse when the mid-frame timeout fires.

Function
REQ-012 SHALL pass byte_valid through a 2-flop synchronizer plus one history flop; byte event = sync2 & ~sync3 (rising edge only).
REQ-013 SHALL capture byte_data into an internal register on the byte-event cycle; byte_data is not otherwise sampled.
REQ-014 SHALL treat one CS-low transaction as exactly one byte; host holds CS low >= 4 clk periods after the last SCK edge and high >= 4 clk periods between transactions (byte_data is cleared when CS rises).
REQ-015 SHALL implement FSM states S_LO (awaiting low byte) and S_HI (awaiting high byte); reset state S_LO.
REQ-016 SHALL, on a byte event in S_LO, store the byte as lo_byte and move to S_HI.
REQ-017 SHALL, on a byte event in S_HI, assert wr_en for exactly the next cycle with wr_data={captured byte, lo_byte} and wr_addr=col_idx, then move to S_LO.
REQ-018 SHALL keep col_idx (10 bits) at reset 0; increment after each write; wrap NUM_COLS-1 -> 0.
REQ-019 SHALL assert frame_done in the same cycle as wr_en when wr_addr==NUM_COLS-1.
REQ-020 SHALL hold wr_addr/wr_data stable between writes (last written values).
REQ-021 SHALL run idle counter (width >= clog2(TIMEOUT_CYCLES)) only when mid-frame (state S_HI or col_idx != 0); clear it on every byte event and whenever not mid-frame.
REQ-022 SHALL, when idle counter reaches TIMEOUT_CYCLES-1, pulse resync_err for one cycle, force S_LO, col_idx=0, clear counter; no write issued.
REQ-023 SHALL give a byte event priority over a timeout in the same cycle: byte processed normally, no resync_err.
REQ-024 SHALL ignore byte_valid held high (no repeat events); a second byte requires byte_valid to fall and rise.
REQ-025 SHALL have latency from byte_valid rise to wr_en of 3-4 clk cycles (2 sync + edge + register stage, plus synchronizer phase).
REQ-026 SHALL never drop a byte event given REQ-014 spacing; no backpressure exists, the column buffer accepts every write.

Reset
REQ-027 SHALL on rst=1 asynchronously set: state S_LO, col_idx 0, lo_byte 0, idle counter 0, synchronizer flops 0, wr_en 0, wr_addr 0, wr_data 0, frame_done 0, resync_err 0.
REQ-028 SHALL, on reset asserted mid-frame, discard any partial word and restart at column 0; the first byte event after reset release is a low byte.
REQ-029 SHALL not generate a byte event if byte_valid is already high when reset releases (history flop captures it without an edge).

Verification
REQ-030 SHALL cover: bytes 0x34 then 0x12 -> single wr_en, wr_addr=0, wr_data=0x1234, 3-4 cycles after second byte_valid rise.
REQ-031 SHALL cover: 1280 bytes (NUM_COLS=640) -> 640 writes, addresses 0..639 in order, frame_done only with addr 639; byte 1281 begins next frame at addr 0.
REQ-032 SHALL cover: low byte 0xAA then silence for TIMEOUT_CYCLES (use 100 in test) -> resync_err pulse, no write; next pair 0x01,0x02 -> addr 0, data 0x0201.
REQ-033 SHALL cover: byte_valid held high 50 cycles -> exactly one byte event.
REQ-034 SHALL cover: rst pulse after 3 words + one low byte -> all outputs 0 immediately; next pair writes addr 0.
REQ-035 SHALL cover: byte event landing on the timeout cycle -> byte accepted, no resync_err.
